// File: rtl/rs_ssc_dsd_serial_decoder.sv
// Serial RS(39,36) SSC-DSD decoder: one symbol per cycle, single-symbol correct, double-symbol detect.
// Optional saturating CE/DUE counters are built when RS_SSC_DSD_ERR_CNT_EN is defined.
module rs_ssc_dsd_serial_decoder #(
  parameter int EARLY_EXIT = 1
`ifdef RS_SSC_DSD_ERR_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [311:0] codeword_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [287:0] data_out,
  output logic [1:0]   status,
  output logic [5:0]   err_loc
`ifdef RS_SSC_DSD_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] due_cnt
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYND   = 3'd1;
  localparam logic [2:0] ST_CLASS  = 3'd2;
  localparam logic [2:0] ST_SEARCH = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] STAT_NE  = 2'b00;
  localparam logic [1:0] STAT_CE  = 2'b01;
  localparam logic [1:0] STAT_DUE = 2'b10;

  // Multiply by alpha: x^8 folds back as x^6+x^4+x^3+x^2+x+1.
  function automatic logic [7:0] mul_a(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h5F : 8'h00);
  endfunction

  function automatic logic [7:0] mul_a2(input logic [7:0] x);
    return mul_a(mul_a(x));
  endfunction

  logic [2:0]   state;
  logic [311:0] cw;
  logic [5:0]   idx;
  logic [7:0]   s0, s1, s2;
  logic [7:0]   t1, t2;
  logic         found;
  logic [5:0]   found_loc;
  logic [7:0]   sym;
  logic         last_syn;
  logic         match;

  always_comb begin
    sym = 8'h00;
    for (int k = 0; k < 36; k++) begin
      if (idx == 6'(k)) sym = cw[311-8*k -: 8];
    end
  end

  assign last_syn  = (idx == 6'd0);
  assign match     = (t1 == s1) && (t2 == s2);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign data_out  = cw[311:24];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cw        <= '0;
      idx       <= '0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      t1        <= '0;
      t2        <= '0;
      found     <= 1'b0;
      found_loc <= '0;
      status    <= STAT_NE;
      err_loc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cw        <= codeword_in;
            s0        <= '0;
            s1        <= '0;
            s2        <= '0;
            idx       <= 6'd35;
            found     <= 1'b0;
            found_loc <= '0;
            status    <= STAT_NE;
            err_loc   <= '0;
            state     <= ST_SYND;
          end
        end

        // Horner evaluation from j=35 down, parity folded in on the final step.
        ST_SYND: begin
          s0 <= s0 ^ sym ^ (last_syn ? cw[23:16] : 8'h00);
          s1 <= mul_a(s1) ^ sym ^ (last_syn ? cw[15:8] : 8'h00);
          s2 <= mul_a2(s2) ^ sym ^ (last_syn ? cw[7:0] : 8'h00);
          if (last_syn) state <= ST_CLASS;
          else          idx   <= idx - 6'd1;
        end

        ST_CLASS: begin
          case ({s2 != 8'h00, s1 != 8'h00, s0 != 8'h00})
            3'b000: begin
              status <= STAT_NE;
              state  <= ST_DONE;
            end
            3'b001: begin
              status  <= STAT_CE;
              err_loc <= 6'd36;
              state   <= ST_DONE;
            end
            3'b010: begin
              status  <= STAT_CE;
              err_loc <= 6'd37;
              state   <= ST_DONE;
            end
            3'b100: begin
              status  <= STAT_CE;
              err_loc <= 6'd38;
              state   <= ST_DONE;
            end
            3'b110: begin
              status <= STAT_DUE;
              state  <= ST_DONE;
            end
            default: begin
              t1    <= s0;
              t2    <= s0;
              idx   <= 6'd0;
              state <= ST_SEARCH;
            end
          endcase
        end

        // T1/T2 track S0*a^j and S0*a^2j; a match pins the error to data symbol j.
        ST_SEARCH: begin
          if (match) begin
            for (int k = 0; k < 36; k++) begin
              if (idx == 6'(k)) cw[311-8*k -: 8] <= sym ^ s0;
            end
            found     <= 1'b1;
            found_loc <= idx;
          end
          if (match && (EARLY_EXIT != 0)) begin
            status  <= STAT_CE;
            err_loc <= idx;
            state   <= ST_DONE;
          end else if (idx == 6'd35) begin
            state <= ST_DONE;
            if (match) begin
              status  <= STAT_CE;
              err_loc <= idx;
            end else if (found) begin
              status  <= STAT_CE;
              err_loc <= found_loc;
            end else begin
              status  <= STAT_DUE;
              err_loc <= '0;
            end
          end else begin
            t1  <= mul_a(t1);
            t2  <= mul_a2(t2);
            idx <= idx + 6'd1;
          end
        end

        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RS_SSC_DSD_ERR_CNT_EN
  logic handshake;
  assign handshake = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt  <= '0;
      due_cnt <= '0;
    end else if (handshake) begin
      if ((status == STAT_CE) && (ce_cnt != '1))   ce_cnt  <= ce_cnt + CNT_W'(1);
      if ((status == STAT_DUE) && (due_cnt != '1)) due_cnt <= due_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rs_ssc_dsd_serial_decoder.sv
// Directed bench for rs_ssc_dsd_serial_decoder: reference encoder plus hand-derived status/latency expectations.
module tb_rs_ssc_dsd_serial_decoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_valid_c;
  logic         in_ready, in_ready_c;
  logic [311:0] codeword_in;
  logic         out_valid, out_valid_c;
  logic         out_ready, out_ready_c;
  logic [287:0] data_out, data_out_c;
  logic [1:0]   status, status_c;
  logic [5:0]   err_loc, err_loc_c;
`ifdef RS_SSC_DSD_ERR_CNT_EN
  logic [15:0]  ce_cnt, due_cnt, ce_cnt_c, due_cnt_c;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rs_ssc_dsd_serial_decoder #(.EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status(status), .err_loc(err_loc)
`ifdef RS_SSC_DSD_ERR_CNT_EN
    , .ce_cnt(ce_cnt), .due_cnt(due_cnt)
`endif
  );

  rs_ssc_dsd_serial_decoder #(.EARLY_EXIT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .codeword_in(codeword_in), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .data_out(data_out_c), .status(status_c), .err_loc(err_loc_c)
`ifdef RS_SSC_DSD_ERR_CNT_EN
    , .ce_cnt(ce_cnt_c), .due_cnt(due_cnt_c)
`endif
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h5F : 8'h00);
    end
    return r;
  endfunction

  // Data symbol j = j+1, parity from P0 = sum d_j, P1 = sum d_j a^j, P2 = sum d_j a^2j.
  function automatic logic [311:0] encode_seq();
    logic [311:0] c = '0;
    logic [7:0] p0 = 8'h00, p1 = 8'h00, p2 = 8'h00;
    logic [7:0] a1 = 8'h01, a2 = 8'h01, d;
    for (int j = 0; j < 36; j++) begin
      d = 8'(j + 1);
      c[311-8*j -: 8] = d;
      p0 = p0 ^ d;
      p1 = p1 ^ gf_mul(d, a1);
      p2 = p2 ^ gf_mul(d, a2);
      a1 = gf_mul(a1, 8'h02);
      a2 = gf_mul(a2, 8'h04);
    end
    c[23:0] = {p0, p1, p2};
    return c;
  endfunction

  task automatic chk(input string tag, input logic [311:0] obs, input logic [311:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the cycle index (accept cycle = 0) at which out_valid is first seen; 200 on timeout.
  task automatic send(input bit sel, input logic [311:0] cw, output int lat);
    @(negedge clk);
    codeword_in = cw;
    if (sel) in_valid_c = 1'b1;
    else     in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_valid_c = 1'b0;
    lat = 1;
    while (!(sel ? out_valid_c : out_valid) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic chk_res(input string tag, input int lat, input int exp_lat,
                         input logic [1:0] exp_st, input logic [5:0] exp_loc,
                         input logic [287:0] exp_dat);
    chk({tag, "_lat"},   312'(lat),       312'(exp_lat));
    chk({tag, "_vld"},   312'(out_valid), 312'(1));
    chk({tag, "_busy"},  312'(in_ready),  312'(0));
    chk({tag, "_stat"},  312'(status),    312'(exp_st));
    chk({tag, "_loc"},   312'(err_loc),   312'(exp_loc));
    chk({tag, "_data"},  312'(data_out),  312'(exp_dat));
  endtask

  task automatic after_hs(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_rdy_next"}, 312'(in_ready),  312'(1));
    chk({tag, "_vld_drop"}, 312'(out_valid), 312'(0));
  endtask

  logic [311:0] enc;
  logic [311:0] cw;
  logic [287:0] orig;
  int lat;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid_c = 1'b0;
    out_ready = 1'b1;
    out_ready_c = 1'b1;
    codeword_in = '0;
    #2;
    chk("rst_in_ready",  312'(in_ready),  312'(1));
    chk("rst_out_valid", 312'(out_valid), 312'(0));
    chk("rst_data",      312'(data_out),  312'(0));
    chk("rst_status",    312'(status),    312'(0));
    chk("rst_err_loc",   312'(err_loc),   312'(0));
`ifdef RS_SSC_DSD_ERR_CNT_EN
    chk("rst_ce_cnt",  312'(ce_cnt),  312'(0));
    chk("rst_due_cnt", 312'(due_cnt), 312'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    enc  = encode_seq();
    orig = enc[311:24];

    send(1'b0, 312'h0, lat);
    chk_res("zero", lat, 38, 2'b00, 6'd0, 288'h0);
    after_hs("zero");

    send(1'b0, enc, lat);
    chk_res("clean", lat, 38, 2'b00, 6'd0, orig);
    after_hs("clean");

    cw = enc;
    cw[271:264] = cw[271:264] ^ 8'hA5;
    send(1'b0, cw, lat);
    chk_res("ce_sym5", lat, 44, 2'b01, 6'd5, orig);
    after_hs("ce_sym5");

    cw = enc;
    cw[15:8] = cw[15:8] ^ 8'h01;
    send(1'b0, cw, lat);
    chk_res("ce_p1", lat, 38, 2'b01, 6'd37, orig);
    after_hs("ce_p1");

    cw = enc;
    cw[311:304] = cw[311:304] ^ 8'h3C;
    cw[31:24]   = cw[31:24] ^ 8'h3C;
    send(1'b0, cw, lat);
    chk_res("due_0_35", lat, 38, 2'b10, 6'd0, cw[311:24]);
    after_hs("due_0_35");

`ifdef RS_SSC_DSD_ERR_CNT_EN
    chk("cnt_ce_after4",  312'(ce_cnt),  312'(2));
    chk("cnt_due_after4", 312'(due_cnt), 312'(1));
`endif

    cw = enc;
    cw[311:304] = cw[311:304] ^ 8'h01;
    cw[303:296] = cw[303:296] ^ 8'h02;
    send(1'b0, cw, lat);
    chk_res("due_search", lat, 74, 2'b10, 6'd0, cw[311:24]);
    after_hs("due_search");

    cw = enc;
    cw[271:264] = cw[271:264] ^ 8'hA5;
    send(1'b1, cw, lat);
    chk("const_lat",  312'(lat),         312'(74));
    chk("const_stat", 312'(status_c),    312'(2'b01));
    chk("const_loc",  312'(err_loc_c),   312'(5));
    chk("const_data", 312'(data_out_c),  312'(orig));
    @(posedge clk);
    #1;
    chk("const_rdy_next", 312'(in_ready_c), 312'(1));

    out_ready = 1'b0;
    cw = enc;
    cw[175:168] = cw[175:168] ^ 8'h5A;
    send(1'b0, cw, lat);
    chk_res("hold_first", lat, 56, 2'b01, 6'd17, orig);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_res("hold", 56, 56, 2'b01, 6'd17, orig);
    end
    @(negedge clk);
    out_ready = 1'b1;
    after_hs("hold_release");

    cw = enc;
    cw[271:264] = cw[271:264] ^ 8'hA5;
    @(negedge clk);
    codeword_in = cw;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("srch_busy",    312'(in_ready),  312'(0));
    chk("srch_no_vld",  312'(out_valid), 312'(0));
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  312'(in_ready),  312'(1));
    chk("arst_out_valid", 312'(out_valid), 312'(0));
    chk("arst_data",      312'(data_out),  312'(0));
`ifdef RS_SSC_DSD_ERR_CNT_EN
    chk("arst_ce_cnt",  312'(ce_cnt),  312'(0));
    chk("arst_due_cnt", 312'(due_cnt), 312'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    cw = enc;
    cw[7:0] = cw[7:0] ^ 8'h80;
    send(1'b0, cw, lat);
    chk_res("ce_p2", lat, 38, 2'b01, 6'd38, orig);
    after_hs("ce_p2");
`ifdef RS_SSC_DSD_ERR_CNT_EN
    chk("cnt_ce_final",  312'(ce_cnt),  312'(1));
    chk("cnt_due_final", 312'(due_cnt), 312'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
